// File: rtl/vga_pkg.sv
// Shared types for the VGA timing generator and the receive-side sync measurement block.
package vga_pkg;

    localparam int unsigned LOCK_CNT_W = 4;

    typedef enum logic [2:0] {
        HUNT,
        ACTIVE,
        FRONTPORCH,
        SYNC,
        BACKPORCH
    } vga_meas_state_t;

    typedef enum logic [1:0] {
        GEN_ACTIVE,
        GEN_FRONTPORCH,
        GEN_SYNC,
        GEN_BACKPORCH
    } vga_gen_state_t;

    // Saturating increment of the lock match counter
    function automatic logic [LOCK_CNT_W-1:0] lock_sat_inc(
        input logic [LOCK_CNT_W-1:0] cnt,
        input logic [LOCK_CNT_W-1:0] lim
    );
        return (cnt >= lim) ? lim : cnt + LOCK_CNT_W'(1);
    endfunction

endpackage

// File: rtl/vga_edge_sample.sv
// Enable-qualified previous-sample registers and rise/fall strobes for active and sync.
// Sync is normalised to an active-high level before edge detection.
module vga_edge_sample #(
    parameter bit sync_pol = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic sync_in,
    input  logic active_in,
    output logic s_lvl_c_o,
    output logic a_lvl_c_o,
    output logic s_rise_c_o,
    output logic s_fall_c_o,
    output logic a_rise_c_o,
    output logic a_fall_c_o
);

    logic s_prev_q;
    logic a_prev_q;
    logic primed_q;
    logic valid_c;

    assign s_lvl_c_o = sync_in ~^ sync_pol;
    assign a_lvl_c_o = active_in;

    // First tick after reset only loads the previous-sample registers
    assign valid_c = enable & primed_q;

    assign s_rise_c_o = valid_c &  s_lvl_c_o & ~s_prev_q;
    assign s_fall_c_o = valid_c & ~s_lvl_c_o &  s_prev_q;
    assign a_rise_c_o = valid_c &  a_lvl_c_o & ~a_prev_q;
    assign a_fall_c_o = valid_c & ~a_lvl_c_o &  a_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_prev_q <= 1'b0;
            a_prev_q <= 1'b0;
            primed_q <= 1'b0;
        end else if (enable) begin
            s_prev_q <= s_lvl_c_o;
            a_prev_q <= a_lvl_c_o;
            primed_q <= 1'b1;
        end
    end

endmodule

// File: rtl/vga_sync_measure.sv
// Measures active / front porch / sync / back porch lengths of one axis of an incoming
// VGA timing stream, tracks position within the cycle and flags lock on stable timing.
module vga_sync_measure
    import vga_pkg::*;
#(
    parameter int unsigned max_len     = 1024,
    parameter int unsigned lock_cycles = 2,
    parameter int unsigned sync_pol    = 1,
    localparam int unsigned len_bit    = $clog2(max_len + 1),
    localparam int unsigned CNT_W      = len_bit + 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               sync_in,
    input  logic               active_in,
    output logic [len_bit-1:0] active_len,
    output logic [len_bit-1:0] frontporch_len,
    output logic [len_bit-1:0] sync_len,
    output logic [len_bit-1:0] backporch_len,
    output logic [CNT_W-1:0]   counter,
    output logic               cycle,
    output logic               locked,
    output logic               error
);

    localparam logic [len_bit-1:0]    MAX_SEG  = len_bit'(max_len);
    localparam logic [LOCK_CNT_W-1:0] LOCK_TGT = LOCK_CNT_W'(lock_cycles);

    vga_meas_state_t state_q, state_d;

    logic [len_bit-1:0]    seg_cnt_q, seg_cnt_d;
    logic [CNT_W-1:0]      counter_q, counter_d;
    logic [len_bit-1:0]    act_len_q, act_len_d;
    logic [len_bit-1:0]    fp_len_q, fp_len_d;
    logic [len_bit-1:0]    sync_len_q, sync_len_d;
    logic [len_bit-1:0]    bp_len_q, bp_len_d;
    logic [len_bit-1:0]    prev_act_q, prev_act_d;
    logic [len_bit-1:0]    prev_fp_q, prev_fp_d;
    logic [len_bit-1:0]    prev_sync_q, prev_sync_d;
    logic [len_bit-1:0]    prev_bp_q, prev_bp_d;
    logic [LOCK_CNT_W-1:0] match_q, match_d;
    logic                  first_q, first_d;
    logic                  cycle_q, cycle_d;
    logic                  error_q, error_d;
    logic                  locked_q, locked_d;

    logic s_lvl_c, a_lvl_c;
    logic s_rise_c, s_fall_c, a_rise_c, a_fall_c;
    logic s_chg_c, a_chg_c;
    logic expect_c;
    logic match_all_c;
    logic [CNT_W-1:0] counter_inc_c;

    vga_edge_sample #(
        .sync_pol (sync_pol != 0)
    ) u_edge (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .sync_in    (sync_in),
        .active_in  (active_in),
        .s_lvl_c_o  (s_lvl_c),
        .a_lvl_c_o  (a_lvl_c),
        .s_rise_c_o (s_rise_c),
        .s_fall_c_o (s_fall_c),
        .a_rise_c_o (a_rise_c),
        .a_fall_c_o (a_fall_c)
    );

    assign s_chg_c = s_rise_c | s_fall_c;
    assign a_chg_c = a_rise_c | a_fall_c;

    assign counter_inc_c = (counter_q == '1) ? counter_q : counter_q + CNT_W'(1);

    // Back porch length is still in seg_cnt at the moment the cycle completes
    assign match_all_c = (act_len_q  == prev_act_q)  &&
                         (fp_len_q   == prev_fp_q)   &&
                         (sync_len_q == prev_sync_q) &&
                         (seg_cnt_q  == prev_bp_q);

    // The one legal terminating edge for each segment; the other signal must be steady
    always_comb begin
        expect_c = 1'b0;
        case (state_q)
            ACTIVE:     expect_c = a_fall_c & ~s_chg_c & ~s_lvl_c;
            FRONTPORCH: expect_c = s_rise_c & ~a_chg_c & ~a_lvl_c;
            SYNC:       expect_c = s_fall_c & ~a_chg_c & ~a_lvl_c;
            BACKPORCH:  expect_c = a_rise_c & ~s_chg_c & ~s_lvl_c;
            default:    expect_c = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        seg_cnt_d   = seg_cnt_q;
        counter_d   = counter_q;
        act_len_d   = act_len_q;
        fp_len_d    = fp_len_q;
        sync_len_d  = sync_len_q;
        bp_len_d    = bp_len_q;
        prev_act_d  = prev_act_q;
        prev_fp_d   = prev_fp_q;
        prev_sync_d = prev_sync_q;
        prev_bp_d   = prev_bp_q;
        match_d     = match_q;
        first_d     = first_q;
        locked_d    = locked_q;
        cycle_d     = 1'b0;
        error_d     = 1'b0;

        if (enable) begin
            if (state_q == HUNT) begin
                if (a_rise_c) begin
                    state_d   = ACTIVE;
                    seg_cnt_d = len_bit'(1);
                    counter_d = '0;
                    first_d   = 1'b1;
                end
            end else if (expect_c) begin
                seg_cnt_d = len_bit'(1);
                counter_d = counter_inc_c;
                case (state_q)
                    ACTIVE: begin
                        act_len_d = seg_cnt_q;
                        state_d   = FRONTPORCH;
                    end
                    FRONTPORCH: begin
                        fp_len_d = seg_cnt_q;
                        state_d  = SYNC;
                    end
                    SYNC: begin
                        sync_len_d = seg_cnt_q;
                        state_d    = BACKPORCH;
                    end
                    default: begin
                        bp_len_d    = seg_cnt_q;
                        state_d     = ACTIVE;
                        counter_d   = '0;
                        cycle_d     = 1'b1;
                        prev_act_d  = act_len_q;
                        prev_fp_d   = fp_len_q;
                        prev_sync_d = sync_len_q;
                        prev_bp_d   = seg_cnt_q;
                        if (first_q) begin
                            first_d = 1'b0;
                            match_d = '0;
                        end else if (match_all_c) begin
                            match_d = lock_sat_inc(match_q, LOCK_TGT);
                        end else begin
                            match_d = '0;
                        end
                        locked_d = (match_d == LOCK_TGT);
                    end
                endcase
            end else if (a_chg_c || s_chg_c || (seg_cnt_q == MAX_SEG)) begin
                // Unexpected edge or segment overrun: drop back to hunting, keep lengths
                state_d   = HUNT;
                error_d   = 1'b1;
                locked_d  = 1'b0;
                match_d   = '0;
                seg_cnt_d = '0;
            end else begin
                seg_cnt_d = seg_cnt_q + len_bit'(1);
                counter_d = counter_inc_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            seg_cnt_q   <= '0;
            counter_q   <= '0;
            act_len_q   <= '0;
            fp_len_q    <= '0;
            sync_len_q  <= '0;
            bp_len_q    <= '0;
            prev_act_q  <= '0;
            prev_fp_q   <= '0;
            prev_sync_q <= '0;
            prev_bp_q   <= '0;
            match_q     <= '0;
            first_q     <= 1'b0;
            cycle_q     <= 1'b0;
            error_q     <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            seg_cnt_q   <= seg_cnt_d;
            counter_q   <= counter_d;
            act_len_q   <= act_len_d;
            fp_len_q    <= fp_len_d;
            sync_len_q  <= sync_len_d;
            bp_len_q    <= bp_len_d;
            prev_act_q  <= prev_act_d;
            prev_fp_q   <= prev_fp_d;
            prev_sync_q <= prev_sync_d;
            prev_bp_q   <= prev_bp_d;
            match_q     <= match_d;
            first_q     <= first_d;
            cycle_q     <= cycle_d;
            error_q     <= error_d;
            locked_q    <= locked_d;
        end
    end

    assign active_len     = act_len_q;
    assign frontporch_len = fp_len_q;
    assign sync_len       = sync_len_q;
    assign backporch_len  = bp_len_q;
    assign counter        = counter_q;
    assign cycle          = cycle_q;
    assign locked         = locked_q;
    assign error          = error_q;

endmodule

// File: doc/vga_sync_measure.md
Name: vga_sync_measure

Overview:
- Receive-side counterpart of the VGA sync generator: samples one axis of an incoming timing stream (sync + active), either horizontal or vertical.
- Measures the four segment lengths (active, front porch, sync, back porch) and reports position within the current cycle.
- Asserts lock once consecutive cycles measure identically.
- Used for video-input bring-up, and as a self-check on the generator's own output.

Parameters:
- max_len, 1024: longest legal segment in enable ticks; len_bit = $clog2(max_len+1).
- lock_cycles, 2: number of consecutive matching full cycles required before locked asserts; range 1..15.
- sync_pol, 1: 1 = sync_in active-high, 0 = active-low; internal sync level = sync_in XNOR sync_pol.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- enable  in  1  tick qualifier; all sampling, counting and state advance happen only on clk edges with enable=1
- sync_in  in  1  incoming sync, polarity per sync_pol
- active_in  in  1  incoming active/blank-n
- active_len  out  len_bit  last measured active length
- frontporch_len  out  len_bit  last measured front porch length
- sync_len  out  len_bit  last measured sync length
- backporch_len  out  len_bit  last measured back porch length
- counter  out  len_bit+2  position in cycle; 0 = first active tick
- cycle  out  1  one-clk pulse: full cycle completed and lengths updated
- locked  out  1  timing stable
- error  out  1  one-clk pulse: illegal sequence or overflow

Behaviour:
- Reset: state=HUNT; all length outputs, counter, seg_cnt and match_cnt = 0; cycle=0, error=0, locked=0. Reset mid-operation aborts immediately with identical values.
- Sampling: each enable tick registers s (internal sync level) and a (active_in). Edges are detected against the previous sample. The first tick after reset only primes the previous-sample registers and detects no edge.
- States and transitions, evaluated on enable ticks:
  - HUNT: on rising a -> ACTIVE; seg_cnt=1, counter=0, first=1.
  - ACTIVE: on falling a with s=0 -> FRONTPORCH; latch active_len=seg_cnt, seg_cnt=1.
  - FRONTPORCH: on rising s with a=0 -> SYNC; latch frontporch_len.
  - SYNC: on falling s with a=0 -> BACKPORCH; latch sync_len.
  - BACKPORCH: on rising a with s=0 -> ACTIVE; latch backporch_len, pulse cycle, counter=0.
  - Otherwise seg_cnt++ and counter++.
- Latency: a latched length appears on its output one clk after the tick that sampled the terminating edge. cycle is registered in the same clk.
- Illegal event, in any non-HUNT state: any edge other than the expected one, or both a and s changing on the same tick. Response:
  - pulse error; go to HUNT; locked=0; match_cnt=0.
  - Length outputs hold their last values.
  - This covers zero-length front porch (active falls and sync rises simultaneously) and sync during active.
- Overflow: seg_cnt==max_len with no edge on the next tick -> error, HUNT. Cycles without active (stalled input) are caught here.
- Lock, evaluated at each cycle pulse:
  - first=1: clear first; match_cnt=0; no compare.
  - Otherwise, if all four new lengths equal the previous four, match_cnt = min(match_cnt+1, lock_cycles); else match_cnt=0 and locked=0.
  - locked = (match_cnt==lock_cycles), registered with cycle.
- enable=0: every register holds; cycle and error are forced to 0.
- counter saturates at all-ones and never wraps mid-cycle.

Decomposition:
- vga_pkg holds typedef enum {HUNT, ACTIVE, FRONTPORCH, SYNC, BACKPORCH} vga_meas_state_t.
- The generator's state enum moves to vga_pkg alongside it.
- One sub-module: vga_edge_sample (enable-qualified sample/previous registers, rise/fall strobes for a and s, sync polarity handling), instantiated once.

Test Plan:
- Stream active=4, fp=2, sync=3, bp=1, enable=1 -> first cycle pulse gives lengths 4/2/3/1 with locked=0; locked=1 at the 3rd cycle pulse (lock_cycles=2); counter runs 0..9.
- Same stream with enable high every 2nd clk -> identical lengths and lock; outputs frozen on enable=0 clks; cycle pulse exactly 1 clk wide.
- Locked stream, then one line with sync=4 -> at that cycle pulse sync_len=4, locked=0; relock after 2 further matching cycles.
- Active falls and sync rises on the same tick -> error pulse, state HUNT, locked=0; resumes measuring at the next rising active.
- sync_pol=0 with inverted sync_in, same 4/2/3/1 stream -> same lengths; active held high for max_len+1 ticks -> error, HUNT.
- rst asserted during SYNC -> next clk all outputs 0, state HUNT; measurement restarts at the next rising active.
